// File: rtl/if_id_stage.sv
// ---------------------------------------------------------------------------
// if_id_stage
//   Fetch stage and IF/ID pipeline register of the RV32I five-stage pipeline.
//   This block does four things:
//     - holds the PC and drives it to a combinational instruction memory
//     - captures the fetched word into the IF/ID register
//     - detects load-use hazards
//     - handles stall and branch flush, and raises the bubble request that
//       zeroes ID/EX control signals
//
//   All state updates on the FALLING edge of clk, in step with the ID/EX
//   register downstream.
//
// Configuration macro:
//   LOAD_USE_DETECT_EN - when defined, an internal load-use comparator
//     drives the stall and bubble outputs. When undefined, load_use is
//     tied to 0, and hazards must be resolved externally via ip_ext_stall.
//
// Ports:
//   clk                   pipeline clock (falling-edge active)
//   reset                 synchronous active-low reset (0 = reset)
//   ip_Instruction[31:0]  imem read data for address op_PC
//   ip_branch_taken       branch/jump resolved taken in EX
//   ip_branch_target      redirect target (bits [1:0] are dropped)
//   ip_ext_stall          external stall request
//   ip_ID_EX_MemRead      instruction in ID/EX is a load
//   ip_ID_EX_rd[4:0]      destination register of that instruction
//   op_PC                 current fetch address
//   op_IF_ID_PC           PC of the instruction held in IF/ID
//   op_IF_ID_Instruction  instruction held in IF/ID
//   op_IF_ID_valid        IF/ID holds a real (non-injected) instruction
//   op_bubble             comb: ID/EX must capture zeroed controls this edge
//   op_stall              comb: PC and IF/ID hold this edge
// ---------------------------------------------------------------------------
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ip_Instruction,
  input  logic        ip_branch_taken,
  input  logic [31:0] ip_branch_target,
  input  logic        ip_ext_stall,
  input  logic        ip_ID_EX_MemRead,
  input  logic [4:0]  ip_ID_EX_rd,
  output logic [31:0] op_PC,
  output logic [31:0] op_IF_ID_PC,
  output logic [31:0] op_IF_ID_Instruction,
  output logic        op_IF_ID_valid,
  output logic        op_bubble,
  output logic        op_stall
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  logic [31:0] pc_q;
  if_id_t      if_id_q;
  logic        load_use;

  // Source register fields of the instruction sitting in IF/ID.
  logic [4:0] rs1, rs2;
  assign rs1 = if_id_q.instr[19:15];
  assign rs2 = if_id_q.instr[24:20];

`ifdef LOAD_USE_DETECT_EN
  // Both source fields are compared regardless of opcode. A false hit only
  // costs one cycle, and it avoids decoding the instruction format here.
  // The valid term keeps injected NOPs (and the reset state) from matching.
  assign load_use = ip_ID_EX_MemRead && (ip_ID_EX_rd != 5'd0) &&
                    ((ip_ID_EX_rd == rs1) || (ip_ID_EX_rd == rs2)) &&
                    if_id_q.valid;
`else
  // Hazards are handled by an external unit through ip_ext_stall.
  assign load_use = 1'b0;
  logic unused_hazard_inputs;
  assign unused_hazard_inputs = ^{ip_ID_EX_MemRead, ip_ID_EX_rd, rs1, rs2};
`endif

  // A taken branch squashes IF/ID anyway, so it cancels any stall.
  assign op_stall  = (load_use || ip_ext_stall) && !ip_branch_taken;
  assign op_bubble = load_use || ip_branch_taken;

  always_ff @(negedge clk) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      if_id_q.pc    <= 32'd0;
      if_id_q.instr <= NOP_INSTR;
      if_id_q.valid <= 1'b0;
    end else if (ip_branch_taken) begin
      pc_q          <= {ip_branch_target[31:2], 2'b00};
      if_id_q.pc    <= 32'd0;
      if_id_q.instr <= NOP_INSTR;
      if_id_q.valid <= 1'b0;
    end else if (!op_stall) begin
      // PC + 4 wraps naturally at 2^32.
      pc_q          <= pc_q + 32'd4;
      if_id_q.pc    <= pc_q;
      if_id_q.instr <= ip_Instruction;
      if_id_q.valid <= 1'b1;
    end
  end

  assign op_PC                = pc_q;
  assign op_IF_ID_PC          = if_id_q.pc;
  assign op_IF_ID_Instruction = if_id_q.instr;
  assign op_IF_ID_valid       = if_id_q.valid;

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Fetch stage and IF/ID pipeline register of the RV32I five-stage pipeline. It holds the program counter, addresses instruction memory, and captures the fetched instruction into the IF/ID register. It sits directly upstream of the decode logic that feeds the ID/EX register. It also owns load-use hazard detection, stall and branch flush, and emits the bubble request that zeroes ID/EX control signals.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, instruction injected on flush/reset (addi x0,x0,0)

Ports:
- clk  input  1  pipeline clock; all state updates on falling edge, matching the ID/EX register
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on falling edge of clk
- ip_Instruction  input  32  instruction memory read data for address op_PC (combinational memory)
- ip_branch_taken  input  1  branch/jump resolved taken in EX
- ip_branch_target  input  32  redirect target, valid when ip_branch_taken=1
- ip_ext_stall  input  1  external stall request (e.g. memory not ready)
- ip_ID_EX_MemRead  input  1  instruction currently in ID/EX is a load
- ip_ID_EX_rd  input  5  destination register of that instruction
- op_PC  output  32  current fetch address to instruction memory
- op_IF_ID_PC  output  32  PC of the instruction in IF/ID
- op_IF_ID_Instruction  output  32  instruction in IF/ID
- op_IF_ID_valid  output  1  IF/ID holds a real (non-injected) instruction
- op_bubble  output  1  combinational; 1 = ID/EX must capture zeroed controls this edge
- op_stall  output  1  combinational; 1 = PC and IF/ID hold this edge

## Operation
- Hazard: load_use = ip_ID_EX_MemRead & (ip_ID_EX_rd != 0) & (ip_ID_EX_rd == IF/ID[19:15] | ip_ID_EX_rd == IF/ID[24:20]) & op_IF_ID_valid. Both source fields compared for every opcode (conservative).
- op_stall = (load_use | ip_ext_stall) & ~ip_branch_taken.
- op_bubble = load_use | ip_branch_taken.
- Per-edge action, priority highest first:
  - reset=0: PC <= RESET_PC; IF/ID PC <= 0; IF/ID instr <= NOP_INSTR; valid <= 0.
  - ip_branch_taken: PC <= ip_branch_target; IF/ID instr <= NOP_INSTR; IF/ID PC <= 0; valid <= 0. Overrides any stall.
  - op_stall: PC, IF/ID PC, IF/ID instr and valid all hold.
  - otherwise: IF/ID PC <= PC; IF/ID instr <= ip_Instruction; valid <= 1; PC <= PC + 4.
- PC arithmetic is 32-bit unsigned; 32'hFFFF_FFFC + 4 wraps to 0. ip_branch_target[1:0] is forced to 2'b00 when loaded.
- A one-cycle load-use stall self-clears: after the bubble, ID/EX no longer holds the load, so load_use drops.

## Timing
- Fetch-to-IF/ID latency: 1 falling edge. The instruction at op_PC appears on op_IF_ID_Instruction after the next falling edge when not stalled.
- Branch penalty: the instruction in IF/ID is squashed and the fetch redirects on the same edge. The target instruction reaches IF/ID one edge later.
- Load-use: exactly 1 stall edge plus 1 bubble per hazard. ip_ext_stall holds for as many edges as it is asserted, with no bubble.
- Reset asserted mid-stall or mid-flush wins immediately at that edge. The first fetch after reset deasserts is from RESET_PC.
- Reset values: op_PC = RESET_PC, op_IF_ID_PC = 0, op_IF_ID_Instruction = NOP_INSTR, op_IF_ID_valid = 0. During reset, op_bubble and op_stall follow the combinational equations, and load_use = 0 because valid = 0.

## Configuration
- LOAD_USE_DETECT_EN defined: internal load-use comparator as described.
- Not defined: load_use is tied to 0. op_stall = ip_ext_stall & ~ip_branch_taken and op_bubble = ip_branch_taken. ip_ID_EX_MemRead and ip_ID_EX_rd are unused. Load-use hazards are then resolved by an external unit through ip_ext_stall.

## Test plan
- Reset and fetch: hold reset=0 for 2 edges, release; imem returns PC-indexed words. Required: op_PC sequence 0,4,8; IF/ID shows the word for PC 0 with valid=1 after the first edge following release.
- Load-use (macro on): IF/ID = 32'h0020_8133 (add x2,x1,x2), ip_ID_EX_MemRead=1, rd=1. Required: op_stall=1 and op_bubble=1 for one edge; PC and IF/ID unchanged; next edge advances normally.
- rd=x0: same as above with rd=0. Required: no stall, no bubble.
- Branch over stall: ip_branch_taken=1, target=32'h0000_0103, with ip_ext_stall=1. Required: op_PC=32'h0000_0100, IF/ID=NOP_INSTR, valid=0, op_bubble=1.
- External stall: ip_ext_stall=1 for 3 edges. Required: PC and IF/ID hold for 3 edges, op_bubble=0, then resume at PC+4.
- Wrap and mid-operation reset: PC=32'hFFFF_FFFC advances, required op_PC=0. Then reset=0 during a load-use stall, required: all outputs return to reset values on that edge.
